lgn_frame_sequencer: RTL

//  Sequences one inference of the logic-gate-network MNIST core. Accepts a

---
 rtl/lgn_frame_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lgn_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lgn_frame_sequencer
// Description : Streams one binarised frame into the LGN core input buffer,
//               waits the evaluation latency and holds the class result.
// Revision    : 1.0 - initial release
// ============================================================================
module lgn_frame_sequencer #(
  parameter int FRAME_BYTES = 98,
  parameter int ADDR_W      = 7,
  parameter int LATENCY     = 8,
  parameter int CLASS_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               abort,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         lgn_data,
  output logic [ADDR_W-1:0]  lgn_addr,
  output logic               lgn_we,
  output logic               lgn_sof,
  input  logic [CLASS_W-1:0] lgn_class,
  output logic [CLASS_W-1:0] res_class,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic [7:0]         frames_done
);

  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] c_last_byte = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [LAT_W-1:0]  c_last_lat  = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [LAT_W-1:0]  r_lat_cnt, w_lat_cnt_nxt;
  logic              w_accept;
  logic              w_capture;
  logic              w_release;

  assign in_ready = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) && !abort;
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
      r_lat_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_lat_cnt  <= w_lat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_lat_cnt_nxt  = r_lat_cnt;
    w_capture      = 1'b0;
    w_release      = 1'b0;
    if (abort) begin
      w_state_nxt    = ST_IDLE;
      w_byte_cnt_nxt = '0;
      w_lat_cnt_nxt  = '0;
      w_release      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // byte_cnt is always 0 here, so the accepted byte is index 0
          if (w_accept) begin
            w_state_nxt    = ST_LOAD;
            w_byte_cnt_nxt = ADDR_W'(1);
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (r_byte_cnt == c_last_byte) begin
              w_state_nxt    = ST_WAIT;
              w_byte_cnt_nxt = '0;
              w_lat_cnt_nxt  = '0;
            end else begin
              w_byte_cnt_nxt = r_byte_cnt + ADDR_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == c_last_lat) begin
            w_capture     = 1'b1;
            w_state_nxt   = ST_DONE;
            w_lat_cnt_nxt = '0;
          end else begin
            w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
          end
        end
        ST_DONE: begin
          if (res_valid && res_ready) begin
            w_release   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Write strobe trails the accept by one cycle; a pending write survives abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lgn_data    <= '0;
      lgn_addr    <= '0;
      lgn_we      <= 1'b0;
      lgn_sof     <= 1'b0;
      res_class   <= '0;
      res_valid   <= 1'b0;
      frames_done <= '0;
    end else begin
      lgn_we  <= w_accept;
      lgn_sof <= w_accept && (r_byte_cnt == '0);
      if (w_accept) begin
        lgn_data <= in_data;
        lgn_addr <= r_byte_cnt;
      end
      if (w_capture) begin
        res_class   <= lgn_class;
        res_valid   <= 1'b1;
        frames_done <= frames_done + 8'd1;
      end else if (w_release) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
